// File: rtl/seq_onehot_enc.sv
// seq_onehot_enc -- sequential one-hot request encoder.
//
// Captures an N-bit request vector and presents it as one or more encoded
// beats on a valid/ready output. Bit N-1 of d maps to index 0 and bit 0 maps
// to index N-1. Index 0 has the highest priority.
//
// Optional feature macro: MULTIHOT_SPLIT_EN
//   defined   : a multi-hot vector becomes one beat per set bit, in ascending
//               index order. Only the final beat has out_last=1.
//   undefined : a multi-hot vector becomes one error beat (idx 0, err, last).
//
// Ports
//   clk        sole clock, rising edge
//   rst        asynchronous active-high reset
//   d          [N-1:0] request vector
//   in_valid   d is valid this cycle
//   in_ready   block can accept d (registered)
//   out_idx    [W-1:0] encoded index of the current beat
//   out_valid  out_idx/out_last/out_err are valid
//   out_ready  consumer accepts the current beat
//   out_last   final beat for the captured vector
//   out_err    beat reports a zero or illegal vector
module seq_onehot_enc #(
    parameter int N = 10,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_idx,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         out_last,
    output logic         out_err
);

    generate
        if (N < 2 || (2 ** W) < N) begin : g_bad_params
            $error("seq_onehot_enc: need N >= 2 and 2**W >= N");
        end
    endgenerate

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e state_q, state_d;
    logic   in_ready_q, in_ready_d;

    logic         accept;
    logic         complete;
    logic [W-1:0] beat_idx;
    logic         beat_last;
    logic         beat_err;

    // in_ready is registered, so accept only happens from IDLE.
    assign accept   = in_valid & in_ready_q;
    assign complete = (state_q == BUSY) & out_ready;

`ifdef MULTIHOT_SPLIT_EN
    // Pending set of request bits still to be emitted.
    logic [N-1:0] p_q, p_d;
    logic [N-1:0] top_mask;

    always_comb begin
        beat_idx = '0;
        top_mask = '0;
        // Highest set bit position is the lowest index; later iterations win.
        for (int i = 0; i < N; i++) begin
            if (p_q[i]) begin
                beat_idx = W'(N - 1 - i);
                top_mask = '0;
                top_mask[i] = 1'b1;
            end
        end
        // At most one bit set: clearing the lowest set bit leaves zero.
        beat_last = ((p_q & (p_q - 1'b1)) == '0);
        beat_err  = (p_q == '0);
    end

    always_comb begin
        p_d = p_q;
        if (accept) begin
            p_d = d;
        end else if (complete) begin
            p_d = p_q & ~top_mask;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
        end else begin
            p_q <= p_d;
        end
    end
`else
    // Only a single beat is ever produced, so the pending vector collapses
    // to the precomputed index plus an error flag.
    logic [W-1:0] idx_q, idx_d;
    logic         err_q, err_d;
    logic [W-1:0] cap_idx;
    logic         cap_onehot;

    always_comb begin
        cap_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (d[i]) begin
                cap_idx = W'(N - 1 - i);
            end
        end
        cap_onehot = (d != '0) && ((d & (d - 1'b1)) == '0);
    end

    always_comb begin
        idx_d = idx_q;
        err_d = err_q;
        if (accept) begin
            idx_d = cap_onehot ? cap_idx : '0;
            err_d = ~cap_onehot;
        end else if (complete) begin
            idx_d = '0;
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx_q <= '0;
            err_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            err_q <= err_d;
        end
    end

    assign beat_idx  = idx_q;
    assign beat_err  = err_q;
    assign beat_last = 1'b1;
`endif

    // Next-state logic. in_ready follows the next state so it is high in the
    // cycle after the last beat completes, and rises one edge after reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (complete && beat_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        in_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    // Beat fields are forced to zero outside BUSY so nothing floats.
    always_comb begin
        in_ready  = in_ready_q;
        out_valid = (state_q == BUSY);
        out_idx   = '0;
        out_last  = 1'b0;
        out_err   = 1'b0;
        if (state_q == BUSY) begin
            out_idx  = beat_idx;
            out_last = beat_last;
            out_err  = beat_err;
        end
    end

endmodule
